pipe_hazard_ctrl: RTL and testbench

Pipeline sequencing controller for the 5-stage RV32 core. Decides every cycle whether the PC, IF/ID and ID/EX registers advance, hold or take a bubble. Covers load-use hazards, taken-branch flushes resolved in EX, and multi-cycle MDU (mul/div) operations held in EX. Sits beside the ID/EX register; a bubble clears that register's control fields (Reg_Con, Mem_Con, Ex_Con, bits 175:160) while the data fields are don't-care.

---
 rtl/core_pkg.sv | 16 +
 rtl/pipe_hazard_ctrl_if.sv | 36 +++
 rtl/pipe_hazard_ctrl.sv | 104 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the RV32 pipeline sequencing controller.
package core_pkg;

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // Control-field slice of the ID/EX register cleared by a bubble.
    localparam int CTRL_MSB = 175;
    localparam int CTRL_LSB = 160;
    localparam int CTRL_W   = CTRL_MSB - CTRL_LSB + 1;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-detection inputs and per-stage sequencing controls between pipeline and controller.
interface pipe_hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_branch_taken;
    logic       ex_mdu_op;
    logic       mdu_done;

    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_en;
    logic       id_ex_bubble;
    logic       ex_mem_bubble;
    logic       mdu_start;

    // Pipeline side: reports decode/execute status, obeys the controls.
    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, ex_mdu_op, mdu_done,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
               ex_mem_bubble, mdu_start
    );

    // Controller side.
    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_branch_taken, ex_mdu_op, mdu_done,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble,
               ex_mem_bubble, mdu_start
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Decides each cycle whether PC, IF/ID and ID/EX advance, hold or take a bubble;
// counts stall cycles and taken-branch flushes.
module pipe_hazard_ctrl
    import core_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    pipe_hazard_ctrl_if.slave   hz,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt
);

    state_t state, state_nxt;
    logic   flush_evt;

    // x0 is hard-wired zero, so a load targeting it never feeds a consumer.
    function automatic logic load_use(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic       use1,
        input logic [4:0] rs2,
        input logic       use2
    );
        return mem_read && (rd != REG_X0) &&
               ((use1 && (rs1 == rd)) || (use2 && (rs2 == rd)));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        flush_evt        = 1'b0;
        hz.pc_en         = 1'b1;
        hz.if_id_en      = 1'b1;
        hz.if_id_flush   = 1'b0;
        hz.id_ex_en      = 1'b1;
        hz.id_ex_bubble  = 1'b0;
        hz.ex_mem_bubble = 1'b0;
        hz.mdu_start     = 1'b0;

        if (rst) begin
            state_nxt        = RUN;
            hz.pc_en         = 1'b0;
            hz.if_id_en      = 1'b0;
            hz.id_ex_en      = 1'b0;
            hz.if_id_flush   = 1'b1;
            hz.id_ex_bubble  = 1'b1;
            hz.ex_mem_bubble = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    // A taken branch wins: whatever sits in ID is wrong-path.
                    if (hz.ex_branch_taken) begin
                        flush_evt       = 1'b1;
                        hz.if_id_flush  = 1'b1;
                        hz.id_ex_bubble = 1'b1;
                    end else if (hz.ex_mdu_op) begin
                        state_nxt        = MDU_WAIT;
                        hz.mdu_start     = 1'b1;
                        hz.pc_en         = 1'b0;
                        hz.if_id_en      = 1'b0;
                        hz.id_ex_en      = 1'b0;
                        hz.ex_mem_bubble = 1'b1;
                    end else if (load_use(hz.ex_mem_read, hz.ex_rd,
                                          hz.id_rs1, hz.id_use_rs1,
                                          hz.id_rs2, hz.id_use_rs2)) begin
                        hz.pc_en        = 1'b0;
                        hz.if_id_en     = 1'b0;
                        hz.id_ex_bubble = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    // EX holds the MDU op here, so no load-use check on release.
                    if (hz.mdu_done) begin
                        state_nxt = RUN;
                    end else begin
                        hz.pc_en         = 1'b0;
                        hz.if_id_en      = 1'b0;
                        hz.id_ex_en      = 1'b0;
                        hz.ex_mem_bubble = 1'b1;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!hz.pc_en) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_evt) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scenarios plus randomized traffic against a rule-level reference model.
module tb_pipe_hazard_ctrl;
    localparam int CNT_W = 4;
    localparam int CNT_M = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    pipe_hazard_ctrl_if bus();

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .hz        (bus),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: "frozen for MDU" flag plus counters as plain integers.
    bit m_wait  = 1'b0;
    int m_stall = 0;
    int m_flush = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Order: {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_bubble, ex_mem_bubble, mdu_start}
    function automatic logic [6:0] model_ctl(
        input bit r, input bit br, input bit mdu, input bit done, input bit mr,
        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
        input bit u1, input bit u2);
        bit hazard;
        hazard = mr && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (r)                return 7'b0010110;
        if (m_wait)           return done ? 7'b1101000 : 7'b0000010;
        if (br)               return 7'b1111100;
        if (mdu)              return 7'b0000011;
        if (hazard)           return 7'b0001100;
        return 7'b1101000;
    endfunction

    task automatic step(input bit r, input bit br, input bit mdu, input bit done,
                        input bit mr, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input bit u1, input bit u2);
        logic [6:0] exp_ctl;
        @(negedge clk);
        rst                 = r;
        bus.ex_branch_taken = br;
        bus.ex_mdu_op       = mdu;
        bus.mdu_done        = done;
        bus.ex_mem_read     = mr;
        bus.ex_rd           = rd;
        bus.id_rs1          = rs1;
        bus.id_rs2          = rs2;
        bus.id_use_rs1      = u1;
        bus.id_use_rs2      = u2;
        #1;
        exp_ctl = model_ctl(r, br, mdu, done, mr, rd, rs1, rs2, u1, u2);
        chk("ctl", {25'd0, bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en,
                    bus.id_ex_bubble, bus.ex_mem_bubble, bus.mdu_start}, {25'd0, exp_ctl});
        @(posedge clk);
        if (r) begin
            m_wait = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            if (!exp_ctl[6])       m_stall = (m_stall + 1) % CNT_M;
            if (!m_wait && br)     m_flush = (m_flush + 1) % CNT_M;
            if (m_wait)            m_wait = !done;
            else                   m_wait = !br && mdu;
        end
        #1;
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    endtask

    task automatic idle(input bit r);
        step(r, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.ex_branch_taken = 0; bus.ex_mdu_op = 0; bus.mdu_done = 0;
        bus.ex_mem_read = 0; bus.ex_rd = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
        bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;

        // Reset state
        idle(1);
        chk("rst_pc_en", 32'(bus.pc_en), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);

        // Load-use on rs1: one stall, then free flow
        step(0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd9, 1, 0);
        chk("lu_stall", 32'(stall_cnt), 32'd1);
        idle(0);
        chk("lu_after", 32'(stall_cnt), 32'd1);

        // Load into x0 never stalls
        idle(1);
        step(0, 0, 0, 0, 1, 5'd0, 5'd3, 5'd0, 0, 1);
        chk("x0_stall", 32'(stall_cnt), 32'd0);

        // Branch masks a simultaneous load-use hazard
        idle(1);
        step(0, 1, 0, 0, 1, 5'd7, 5'd7, 5'd7, 1, 1);
        chk("br_flush", 32'(flush_cnt), 32'd1);
        chk("br_stall", 32'(stall_cnt), 32'd0);

        // MDU with done arriving 4 cycles after start
        idle(1);
        step(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        step(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(0);
        idle(0);
        step(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        chk("mdu_stall", 32'(stall_cnt), 32'd4);
        chk("mdu_flush", 32'(flush_cnt), 32'd0);
        idle(0);
        chk("mdu_run_pc_en", 32'(bus.pc_en), 32'd1);

        // Reset in the second wait cycle
        idle(1);
        step(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
        idle(0);
        idle(1);
        chk("rmdu_stall", 32'(stall_cnt), 32'd0);
        idle(0);
        chk("rmdu_pc_en", 32'(bus.pc_en), 32'd1);

        // 17 load-use stalls wrap a 4-bit counter to 1
        idle(1);
        for (int i = 0; i < 17; i++) begin
            step(0, 0, 0, 0, 1, 5'd12, 5'd1, 5'd12, 0, 1);
            idle(0);
        end
        chk("wrap_stall", 32'(stall_cnt), 32'd1);

        // Randomized traffic over a small register range to provoke matches
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 63) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 7) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
